// File: rtl/approx_error_monitor.sv
// Error-distance monitor for an 8-bit approximate adder: accepts SAMPLES operand
// pairs per run and accumulates error count, summed and maximum error distance.
module approx_error_monitor #(
  parameter int unsigned SAMPLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  approx_sum,
  input  logic        approx_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_count,
  output logic [24:0] sum_ed,
  output logic [8:0]  max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LIMIT = 16'(SAMPLES);
  localparam logic [15:0] LAST  = 16'(SAMPLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic [24:0] sum_q, sum_d;
  logic [8:0]  max_q, max_d;

  logic        s1_valid_q;
  logic [7:0]  s1_a_q, s1_b_q;
  logic [8:0]  s1_approx_q;

  logic        accept;
  logic [8:0]  exact;
  logic [8:0]  ed;

  assign in_ready = (state_q == RUN) && (cnt_q < LIMIT);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;

  // Exact sum and approximate result are both 9 bits, so |diff| fits in 9 bits.
  assign exact = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign ed    = (exact >= s1_approx_q) ? (exact - s1_approx_q) : (s1_approx_q - exact);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;

    if (s1_valid_q) begin
      sum_d = sum_q + 25'(ed);
      if (ed != 9'd0) err_d = err_q + 16'd1;
      if (ed > max_q) max_d = ed;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_approx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q      <= in0;
        s1_b_q      <= in1;
        s1_approx_q <= {approx_cout, approx_sum};
      end
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor using three instances (SAMPLES = 4, 3, 1)
// sharing one operand bus; each run is started on exactly one instance.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start3, start1;
  logic        in_valid;
  logic [7:0]  in0, in1, approx_sum;
  logic        approx_cout;

  logic        rdy4, busy4, done4;
  logic [15:0] err4;
  logic [24:0] sum4;
  logic [8:0]  max4;
  logic        rdy3, busy3, done3;
  logic [15:0] err3;
  logic [24:0] sum3;
  logic [8:0]  max3;
  logic        rdy1, busy1, done1;
  logic [15:0] err1;
  logic [24:0] sum1;
  logic [8:0]  max1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  approx_error_monitor #(.SAMPLES(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
    .in0(in0), .in1(in1), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .busy(busy4), .done(done4), .err_count(err4), .sum_ed(sum4), .max_ed(max4)
  );

  approx_error_monitor #(.SAMPLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid), .in_ready(rdy3),
    .in0(in0), .in1(in1), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .busy(busy3), .done(done3), .err_count(err3), .sum_ed(sum3), .max_ed(max3)
  );

  approx_error_monitor #(.SAMPLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
    .in0(in0), .in1(in1), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .busy(busy1), .done(done1), .err_count(err1), .sum_ed(sum1), .max_ed(max1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; the pair is accepted on the following posedge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
    in0 = a;
    in1 = b;
    {approx_cout, approx_sum} = ap;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  function automatic int ed_of(input int a, input int b, input int ap);
    int d;
    d = a + b - ap;
    return (d < 0) ? -d : d;
  endfunction

  task automatic check_final4(input string tag, input int e, input int s, input int m);
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_err"},  32'(err4),  32'(e));
    check({tag, "_sum"},  32'(sum4),  32'(s));
    check({tag, "_max"},  32'(max4),  32'(m));
  endtask

  initial begin
    bit   vpat [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    int   acc, dones, exp_err, exp_sum, exp_max, ed, ex;
    logic [7:0] a, b;
    logic [8:0] ap;

    rst = 1'b1;
    start4 = 1'b0; start3 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; in0 = '0; in1 = '0; approx_sum = '0; approx_cout = 1'b0;

    // Reset state
    #1;
    check("rst_rdy",  32'(rdy4),  32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_err",  32'(err4),  32'd0);
    check("rst_sum",  32'(sum4),  32'd0);
    check("rst_max",  32'(max4),  32'd0);
    check("rst_rdy1", 32'(rdy1),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back run: only (100,100 -> 196) is wrong, ED 4
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("t1_busy", 32'(busy4), 32'd1);
    check("t1_rdy",  32'(rdy4),  32'd1);
    send(8'd10, 8'd20, 9'd30);
    send(8'd255, 8'd1, 9'h100);
    send(8'd100, 8'd100, 9'd196);
    check("t1_sum_before", 32'(sum4), 32'd0);
    send(8'd3, 8'd4, 9'd7);
    in_valid = 1'b0;
    check("t1_lat_sum", 32'(sum4),  32'd4);
    check("t1_drain_rdy",  32'(rdy4),  32'd0);
    check("t1_drain_busy", 32'(busy4), 32'd1);
    check("t1_drain_done", 32'(done4), 32'd0);
    @(negedge clk);
    check_final4("t1", 1, 4, 4);
    @(negedge clk);
    check("t1_done_low", 32'(done4), 32'd0);
    check("t1_idle_busy", 32'(busy4), 32'd0);
    check("t1_hold_sum", 32'(sum4), 32'd4);

    // Extreme error distances: 510, 0, 1
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    send(8'd255, 8'd255, 9'd0);
    send(8'd0, 8'd0, 9'd0);
    send(8'd1, 8'd1, 9'd3);
    in_valid = 1'b0;
    check("t2_rdy_off", 32'(rdy3), 32'd0);
    @(negedge clk);
    check("t2_done", 32'(done3), 32'd1);
    check("t2_err",  32'(err3),  32'd2);
    check("t2_sum",  32'(sum3),  32'd511);
    check("t2_max",  32'(max3),  32'd510);
    @(negedge clk);
    check("t2_done_low", 32'(done3), 32'd0);

    // Gapped in_valid with scoreboard; valid keeps toggling past the 4th accept
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    acc = 0; dones = 0; exp_err = 0; exp_sum = 0; exp_max = 0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_rdy%0d", i), 32'(rdy4), (acc < 4) ? 32'd1 : 32'd0);
      if (done4) dones++;
      a  = 8'(i * 37 + 9);
      b  = 8'(i * 11 + 5);
      ex = int'(a) + int'(b);
      ap = 9'(ex ^ (i % 3));
      in0 = a; in1 = b; {approx_cout, approx_sum} = ap;
      in_valid = vpat[i];
      if (vpat[i] && acc < 4) begin
        acc++;
        ed = ed_of(int'(a), int'(b), int'(ap));
        exp_sum += ed;
        if (ed != 0) exp_err++;
        if (ed > exp_max) exp_max = ed;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t3_done_pulses", 32'(dones), 32'd1);
    check("t3_err", 32'(err4), 32'(exp_err));
    check("t3_sum", 32'(sum4), 32'(exp_sum));
    check("t3_max", 32'(max4), 32'(exp_max));
    check("t3_busy", 32'(busy4), 32'd0);

    // Reset after two accepts, then a fresh run started on the first edge
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    send(8'd100, 8'd100, 9'd196);
    send(8'd255, 8'd255, 9'd0);
    in_valid = 1'b0;
    check("t4_pre_sum", 32'(sum4), 32'd4);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy4), 32'd0);
    check("t4_rst_done", 32'(done4), 32'd0);
    check("t4_rst_err",  32'(err4),  32'd0);
    check("t4_rst_sum",  32'(sum4),  32'd0);
    check("t4_rst_max",  32'(max4),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("t4_restart_busy", 32'(busy4), 32'd1);
    check("t4_restart_done", 32'(done4), 32'd0);
    check("t4_restart_sum",  32'(sum4),  32'd0);
    send(8'd10, 8'd20, 9'd30);
    send(8'd255, 8'd1, 9'h100);
    send(8'd100, 8'd100, 9'd196);
    send(8'd3, 8'd4, 9'd7);
    in_valid = 1'b0;
    @(negedge clk);
    check_final4("t4", 1, 4, 4);
    @(negedge clk);

    // start held through the run, then a new start right after done
    start4 = 1'b1;
    @(negedge clk);
    send(8'd100, 8'd100, 9'd196);
    send(8'd50, 8'd60, 9'd100);
    send(8'd1, 8'd2, 9'd3);
    send(8'd0, 8'd255, 9'd255);
    in_valid = 1'b0;
    check("t5_drain_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    start4 = 1'b0;
    check_final4("t5", 2, 14, 10);
    @(negedge clk);
    check("t5_idle_busy", 32'(busy4), 32'd0);
    check("t5_idle_done", 32'(done4), 32'd0);
    check("t5_hold_err",  32'(err4),  32'd2);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("t5_new_busy", 32'(busy4), 32'd1);
    check("t5_new_err",  32'(err4),  32'd0);
    check("t5_new_sum",  32'(sum4),  32'd0);
    check("t5_new_max",  32'(max4),  32'd0);
    send(8'd3, 8'd4, 9'd8);
    send(8'd10, 8'd20, 9'd30);
    send(8'd10, 8'd20, 9'd30);
    send(8'd10, 8'd20, 9'd30);
    in_valid = 1'b0;
    @(negedge clk);
    check_final4("t5b", 1, 1, 1);
    @(negedge clk);

    // SAMPLES=1: accept, DRAIN, DONE
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t6_rdy", 32'(rdy1), 32'd1);
    send(8'd7, 8'd9, 9'd12);
    in_valid = 1'b0;
    check("t6_drain_rdy",  32'(rdy1),  32'd0);
    check("t6_drain_busy", 32'(busy1), 32'd1);
    check("t6_drain_done", 32'(done1), 32'd0);
    @(negedge clk);
    check("t6_done", 32'(done1), 32'd1);
    check("t6_err",  32'(err1),  32'd1);
    check("t6_sum",  32'(sum1),  32'd4);
    check("t6_max",  32'(max1),  32'd4);
    @(negedge clk);
    check("t6_done_low", 32'(done1), 32'd0);
    check("t6_idle_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
